// File: rtl/ice_bus_pkg.sv
// Shared types and helpers for the ICE slave-bus arbiter.
package ice_bus_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  // Arbitration policy selected by arb_mode.
  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Increment a device index, wrapping to zero at n (n need not be a power of two).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/ice_bus_arbiter_if.sv
// Request/grant bundle between the requesting devices and the slave-bus arbiter.
interface ice_bus_arbiter_if #(
  parameter int unsigned NUM_DEV   = 7,
  parameter int unsigned TIMEOUT_W = 16
) ();

  localparam int unsigned IDX_W = $clog2(NUM_DEV);

  logic [NUM_DEV-1:0]   sl_arb_request;
  logic                 sl_latch_tail;
  logic                 arb_mode;
  logic [TIMEOUT_W-1:0] timeout_limit;
  logic [NUM_DEV-1:0]   sl_arb_grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 bus_busy;
  logic                 timeout_evt;
  logic [7:0]           timeout_count;

  // Requesting side: drives requests and configuration, observes the grant.
  modport master (
    output sl_arb_request, sl_latch_tail, arb_mode, timeout_limit,
    input  sl_arb_grant, grant_idx, bus_busy, timeout_evt, timeout_count
  );

  // Arbiter side.
  modport slave (
    input  sl_arb_request, sl_latch_tail, arb_mode, timeout_limit,
    output sl_arb_grant, grant_idx, bus_busy, timeout_evt, timeout_count
  );

endinterface

// File: rtl/ice_rr_pick.sv
// Combinational masked priority picker: lowest set request in fixed mode, or the first set
// request at/above ptr_i (wrapping modulo NUM_DEV) in round-robin mode.
module ice_rr_pick
  import ice_bus_pkg::*;
#(
  parameter  int unsigned NUM_DEV = 7,
  localparam int unsigned IDX_W   = $clog2(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               mode_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               found_o
);

  // One extra bit so start + offset cannot overflow before the explicit wrap.
  logic [IDX_W:0] start;
  logic [IDX_W:0] cand;

  // Scan candidates in priority order and keep the first requesting one.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    start    = (mode_i == ARB_RR) ? {1'b0, ptr_i} : '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      cand = start + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_DEV)) begin
        cand = cand - (IDX_W + 1)'(NUM_DEV);
      end
      if (!found_o && req_i[cand[IDX_W-1:0]]) begin
        found_o  = 1'b1;
        winner_o = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ice_bus_arbiter.sv
// Slave-bus arbiter: grants one requester for a whole frame, enforces an inter-frame gap and
// reclaims the bus through a watchdog when the owner never ends its frame.
module ice_bus_arbiter
  import ice_bus_pkg::*;
#(
  parameter int unsigned NUM_DEV    = 7,
  parameter int unsigned TIMEOUT_W  = 16,
  parameter int unsigned GAP_CYCLES = 1
) (
  input logic              clk,
  input logic              reset,
  ice_bus_arbiter_if.slave bus_if
);

  localparam int unsigned          IDX_W   = $clog2(NUM_DEV);
  localparam logic [TIMEOUT_W-1:0] GapLast = TIMEOUT_W'(GAP_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [NUM_DEV-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 evt_q, evt_d;
  logic [7:0]           tcount_q, tcount_d;

  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic                 owner_req;
  logic                 expire;
  logic [TIMEOUT_W-1:0] cnt_inc;

  ice_rr_pick #(
    .NUM_DEV (NUM_DEV)
  ) u_pick (
    .req_i    (bus_if.sl_arb_request),
    .ptr_i    (rr_ptr_q),
    .mode_i   (bus_if.arb_mode),
    .winner_o (winner),
    .found_o  (found)
  );

  assign owner_req = bus_if.sl_arb_request[idx_q];
  // Counter holds (grant cycles - 1), so a match means the grant has lasted timeout_limit cycles.
  assign expire    = (bus_if.timeout_limit != '0) &&
                     (cnt_q == bus_if.timeout_limit - TIMEOUT_W'(1));
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);

  // Next-state: arbitration in IDLE, frame hold and exit causes in GRANT, dead time in GAP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    evt_d    = 1'b0;
    tcount_d = tcount_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          grant_d  = NUM_DEV'(1) << winner;
          idx_d    = winner;
          rr_ptr_d = IDX_W'(wrap_inc(32'(winner), NUM_DEV));
          cnt_d    = '0;
          state_d  = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        cnt_d = cnt_inc;
        if (bus_if.sl_latch_tail || !owner_req || expire) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = ARB_GAP;
          // Tail and abandon outrank the watchdog: only a pure expiry is a revocation.
          if (!bus_if.sl_latch_tail && owner_req) begin
            evt_d    = 1'b1;
            tcount_d = (tcount_q == 8'hFF) ? tcount_q : tcount_q + 8'd1;
          end
        end
      end
      ARB_GAP: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      cnt_q    <= '0;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      evt_q    <= 1'b0;
      tcount_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      evt_q    <= evt_d;
      tcount_q <= tcount_d;
    end
  end

  assign bus_if.sl_arb_grant  = grant_q;
  assign bus_if.grant_idx     = idx_q;
  assign bus_if.bus_busy      = |grant_q;
  assign bus_if.timeout_evt   = evt_q;
  assign bus_if.timeout_count = tcount_q;

endmodule

// File: tb/tb_ice_bus_arbiter.sv
// Self-checking bench for ice_bus_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a frame-level reference model.
module tb_ice_bus_arbiter;

  localparam int unsigned NUM_DEV    = 7;
  localparam int unsigned TIMEOUT_W  = 16;
  localparam int unsigned GAP_CYCLES = 1;
  localparam int          N          = NUM_DEV;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: current owner (-1 = none), last owner, grant cycles so far,
  // gap cycles left, round-robin start, event pulse and revocation count.
  int m_owner  = -1;
  int m_last   = 0;
  int m_held   = 0;
  int m_gap    = 0;
  int m_rr     = 0;
  int m_tcount = 0;
  bit m_evt    = 1'b0;

  logic [TIMEOUT_W-1:0] lims [6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};

  ice_bus_arbiter_if #(
    .NUM_DEV   (NUM_DEV),
    .TIMEOUT_W (TIMEOUT_W)
  ) bus_if ();

  ice_bus_arbiter #(
    .NUM_DEV    (NUM_DEV),
    .TIMEOUT_W  (TIMEOUT_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input logic rst, input logic [NUM_DEV-1:0] req, input logic tail,
                            input logic mode, input logic [TIMEOUT_W-1:0] limit);
    int reqs;
    int lim;
    int c;
    bit own_req;
    reqs  = int'(req);
    lim   = int'(limit);
    m_evt = 1'b0;
    if (rst) begin
      m_owner = -1; m_last = 0; m_held = 0; m_gap = 0; m_rr = 0; m_tcount = 0;
    end else if (m_owner >= 0) begin
      own_req = ((reqs >> m_owner) & 1) != 0;
      if (tail || !own_req || (lim != 0 && m_held == lim)) begin
        if (!tail && own_req) begin
          m_evt = 1'b1;
          if (m_tcount < 255) m_tcount++;
        end
        m_owner = -1;
        m_gap   = GAP_CYCLES;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = mode ? (m_rr + k) % N : k;
        if (m_owner < 0 && ((reqs >> c) & 1) != 0) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_held = 1;
        m_rr   = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic compare_all();
    int exp_grant;
    exp_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
    check_eq("grant", 32'(bus_if.sl_arb_grant), 32'(exp_grant));
    check_eq("grant_idx", 32'(bus_if.grant_idx), 32'(m_last));
    check_eq("bus_busy", 32'(bus_if.bus_busy), 32'(m_owner >= 0));
    check_eq("timeout_evt", 32'(bus_if.timeout_evt), 32'(m_evt));
    check_eq("timeout_count", 32'(bus_if.timeout_count), 32'(m_tcount));
  endtask

  // Called at a negedge: drive inputs, cross one posedge, compare at the next negedge.
  task automatic step(input logic rst, input logic [NUM_DEV-1:0] req, input logic tail,
                      input logic mode, input logic [TIMEOUT_W-1:0] limit);
    reset                 = rst;
    bus_if.sl_arb_request = req;
    bus_if.sl_latch_tail  = tail;
    bus_if.arb_mode       = mode;
    bus_if.timeout_limit  = limit;
    model_step(rst, req, tail, mode, limit);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_busy(input logic [NUM_DEV-1:0] req, input logic mode,
                           input logic [TIMEOUT_W-1:0] limit);
    int n;
    n = 0;
    while (!bus_if.bus_busy && n < 10) begin
      step(1'b0, req, 1'b0, mode, limit);
      n++;
    end
    check_eq("wait_busy", 32'(bus_if.bus_busy), 32'd1);
  endtask

  initial begin
    int n_hi;
    int n_evt;
    int budget;
    logic [NUM_DEV-1:0]   cur_req;
    logic                 cur_mode;
    logic [TIMEOUT_W-1:0] cur_lim;

    bus_if.sl_arb_request = '0;
    bus_if.sl_latch_tail  = 1'b0;
    bus_if.arb_mode       = 1'b0;
    bus_if.timeout_limit  = '0;
    @(negedge clk);
    step(1'b1, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0);

    // Fixed priority: devices 1 and 3 request, 1 wins; tail at cycle 5; 3 wins at cycle 8.
    step(1'b0, 7'b0001010, 1'b0, 1'b0, '0);
    check_eq("fx_grant_c1", 32'(bus_if.sl_arb_grant), 32'h02);
    repeat (4) step(1'b0, 7'b0001010, 1'b0, 1'b0, '0);
    step(1'b0, 7'b0001010, 1'b1, 1'b0, '0);
    check_eq("fx_drop_c6", 32'(bus_if.sl_arb_grant), 32'h00);
    step(1'b0, 7'b0001000, 1'b0, 1'b0, '0);
    check_eq("fx_gap_c7", 32'(bus_if.sl_arb_grant), 32'h00);
    step(1'b0, 7'b0001000, 1'b0, 1'b0, '0);
    check_eq("fx_grant_c8", 32'(bus_if.sl_arb_grant), 32'h08);
    step(1'b0, 7'b0001000, 1'b1, 1'b0, '0);

    // Round robin with every device requesting: owners rotate 0..6 then wrap to 0.
    step(1'b1, '0, 1'b0, 1'b1, '0);
    for (int f = 0; f < 8; f++) begin
      wait_busy('1, 1'b1, '0);
      check_eq("rr_idx", 32'(bus_if.grant_idx), 32'(f % 7));
      repeat (3) step(1'b0, '1, 1'b0, 1'b1, '0);
      step(1'b0, '1, 1'b1, 1'b1, '0);
    end

    // Watchdog: device 5 never ends its frame; grant lasts exactly 10 cycles, one event.
    step(1'b1, '0, 1'b0, 1'b0, 16'd10);
    wait_busy(7'b0100000, 1'b0, 16'd10);
    n_hi = 0; n_evt = 0;
    while (bus_if.bus_busy && n_hi < 50) begin
      n_hi++;
      step(1'b0, 7'b0100000, 1'b0, 1'b0, 16'd10);
      if (bus_if.timeout_evt) n_evt++;
    end
    check_eq("to_len", 32'(n_hi), 32'd10);
    check_eq("to_evt_cnt", 32'(n_evt), 32'd1);
    check_eq("to_count", 32'(bus_if.timeout_count), 32'd1);

    // Tail in the expiry cycle is a normal release.
    wait_busy(7'b0100000, 1'b0, 16'd10);
    repeat (9) step(1'b0, 7'b0100000, 1'b0, 1'b0, 16'd10);
    step(1'b0, 7'b0100000, 1'b1, 1'b0, 16'd10);
    check_eq("tail_exp_busy", 32'(bus_if.bus_busy), 32'd0);
    check_eq("tail_exp_evt", 32'(bus_if.timeout_evt), 32'd0);
    check_eq("tail_exp_count", 32'(bus_if.timeout_count), 32'd1);

    // Abandon: device 2 drops its request at cycle 3, grant gone at cycle 4, no event.
    step(1'b1, '0, 1'b0, 1'b1, '0);
    step(1'b0, 7'b0000100, 1'b0, 1'b1, '0);
    check_eq("ab_grant_c1", 32'(bus_if.sl_arb_grant), 32'h04);
    repeat (2) step(1'b0, 7'b0000100, 1'b0, 1'b1, '0);
    step(1'b0, 7'b0000000, 1'b0, 1'b1, '0);
    check_eq("ab_drop_c4", 32'(bus_if.sl_arb_grant), 32'h00);
    check_eq("ab_evt", 32'(bus_if.timeout_evt), 32'd0);

    // Reset mid-grant clears everything, including the round-robin pointer.
    wait_busy(7'b0000100, 1'b1, '0);
    step(1'b1, 7'b0000100, 1'b0, 1'b1, '0);
    check_eq("rst_grant", 32'(bus_if.sl_arb_grant), 32'h00);
    check_eq("rst_evt", 32'(bus_if.timeout_evt), 32'd0);
    step(1'b0, '1, 1'b0, 1'b1, '0);
    check_eq("rst_rr_ptr", 32'(bus_if.grant_idx), 32'd0);
    check_eq("rst_rr_busy", 32'(bus_if.bus_busy), 32'd1);

    // 300 forced revocations saturate the counter at 255.
    step(1'b1, '0, 1'b0, 1'b0, 16'd1);
    n_evt = 0; budget = 0;
    while (n_evt < 300 && budget < 2000) begin
      step(1'b0, 7'b0000001, 1'b0, 1'b0, 16'd1);
      if (bus_if.timeout_evt) n_evt++;
      budget++;
    end
    check_eq("sat_evts", 32'(n_evt), 32'd300);
    check_eq("sat_count", 32'(bus_if.timeout_count), 32'd255);

    // Watchdog disabled: a 70000-cycle hold is never revoked.
    step(1'b1, '0, 1'b0, 1'b0, '0);
    wait_busy(7'b0000001, 1'b0, '0);
    repeat (70000) step(1'b0, 7'b0000001, 1'b0, 1'b0, '0);
    check_eq("hold_busy", 32'(bus_if.bus_busy), 32'd1);
    check_eq("hold_count", 32'(bus_if.timeout_count), 32'd0);
    step(1'b0, 7'b0000001, 1'b1, 1'b0, '0);

    // Randomized traffic with mode, limit, tail and occasional reset all varying.
    cur_req  = '0;
    cur_mode = 1'b0;
    cur_lim  = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) cur_req = NUM_DEV'($urandom);
      if ($urandom_range(0, 31) == 0) cur_mode = ~cur_mode;
      if ($urandom_range(0, 15) == 0) cur_lim = lims[$urandom_range(0, 5)];
      step(($urandom_range(0, 299) == 0), cur_req, ($urandom_range(0, 5) == 0),
           cur_mode, cur_lim);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ice_bus_arbiter.md
Name: ice_bus_arbiter

Overview:
- Parametrised slave-bus arbiter for the ICE bus controller. Grants exactly one of NUM_DEV requesting interfaces (basics, MBus, EIN, PMU, ...) ownership of the shared slave output bus for one frame.
- Generalises the fixed request/grant vector: runtime-selectable fixed-priority or round-robin policy, frame-level grant hold, an inter-frame gap, and a watchdog that reclaims the bus from a stuck device.

Parameters:
- NUM_DEV, 7, number of requesting devices (>= 2).
- TIMEOUT_W, 16, width of the watchdog limit and cycle counter.
- GAP_CYCLES, 1, idle cycles with no grant between frames (>= 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- sl_arb_request  input  NUM_DEV  per-device bus request, level.
- sl_latch_tail  input  1  granted device latching its frame tail; marks end of frame.
- arb_mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- timeout_limit  input  TIMEOUT_W  maximum grant length in cycles; 0 disables the watchdog.
- sl_arb_grant  output  NUM_DEV  one-hot grant, or all zero.
- grant_idx  output  IDX_W  index of the current or last owner; IDX_W = $clog2(NUM_DEV).
- bus_busy  output  1  high while any grant is asserted.
- timeout_evt  output  1  one-cycle pulse when the watchdog revokes a grant.
- timeout_count  output  8  saturating count of watchdog revocations.

Behaviour:
- Reset: all outputs 0, rr_ptr = 0, state = IDLE, cycle counter = 0. Reset during GRANT drops the grant on the next edge; no timeout_evt is produced.
- IDLE state:
  - If any request is high, compute the winner combinationally and register the grant. sl_arb_grant is valid one cycle after the request is sampled.
  - Load grant_idx with the winner, go to GRANT, clear the cycle counter.
- Fixed-priority mode: winner is the lowest set index.
- Round-robin mode:
  - Winner is the first set index at or above rr_ptr, searching upward and wrapping modulo NUM_DEV.
  - On every grant, rr_ptr <= winner + 1; it wraps to 0 when winner = NUM_DEV-1.
  - rr_ptr is maintained in both modes, so switching mode takes effect at the next IDLE decision. arb_mode is not sampled mid-grant.
- GRANT state: grant is held constant. The counter increments each cycle and saturates at all-ones. The state exits to GAP on the first of these conditions:
  - (a) sl_latch_tail = 1: normal frame end.
  - (b) the owner's request deasserts: abandon, no event.
  - (c) timeout_limit != 0 and counter == timeout_limit-1: revoke. timeout_evt pulses high in the cycle the grant drops. timeout_count increments and saturates at 255.
  - Priority of simultaneous exit causes: (a) > (b) > (c). A tail on the same cycle as an expiry produces no timeout_evt.
- Grant drop timing: sl_arb_grant goes to 0 the cycle after the exit condition is sampled. bus_busy follows the grant with identical timing.
- GAP state: grant stays 0 for GAP_CYCLES cycles, then the block returns to IDLE. Requests seen during GAP are only arbitrated in IDLE, so back-to-back frames are separated by GAP_CYCLES+1 grant-free cycles minimum.
- Invariants:
  - At most one grant bit is ever high.
  - No device is granted without its request high in the deciding cycle.
  - Requests from a non-owner during GRANT never affect the grant.
- Width rules: index arithmetic is in IDX_W bits with an explicit wrap at NUM_DEV (non-power-of-2 NUM_DEV is supported). Counter comparison is unsigned.

Decomposition:
- Shared package `ice_bus_pkg`:
  - state encoding constants ARB_IDLE / ARB_GRANT / ARB_GAP;
  - mode constants ARB_FIXED = 0, ARB_RR = 1;
  - `SD delay macro from the common include.
- One sub-module, `ice_rr_pick`: combinational masked priority picker. Inputs: request vector, start pointer, mode. Outputs: winner index and a found flag. Parametrised by NUM_DEV. It is instantiated once and its outputs are registered by the FSM.

Test Plan:
- Fixed mode, requests 0b0001010 asserted at cycle 0 -> grant 0b0000010 at cycle 1. Tail pulse at cycle 5 -> grant 0 at cycle 6. Device 3 granted at cycle 8 (GAP_CYCLES = 1).
- RR mode, all 7 requests held high, tail pulse every 4th granted cycle -> grant_idx sequence 0,1,2,3,4,5,6,0. rr_ptr wraps 6 -> 0.
- timeout_limit = 10, device 5 holds its request with no tail -> grant high for 10 cycles. timeout_evt is a single pulse as the grant drops. timeout_count = 1.
- timeout_limit = 10, tail asserted in the expiry cycle -> normal release, timeout_evt stays 0, timeout_count unchanged.
- Device 2 granted, then its request drops at cycle 3 with no tail -> grant drops at cycle 4, no event. Reset asserted mid-GRANT -> all outputs 0 on the next edge and rr_ptr = 0.
- 300 forced timeouts -> timeout_count saturates at 255. timeout_limit = 0 with a 70000-cycle hold -> grant never revoked.
